elastic_pipe_3: RTL and testbench

//  Valid/ready elastic pipeline: DEPTH register stages with a backpressure path and bubble collapsing.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_skid_buf.sv | 44 ++++
 rtl/elastic_pipe_3.sv | 102 ++++++++++
 tb/tb_elastic_pipe_3.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic valid/ready pipeline.
package pipe_pkg;

  localparam int PIPE_DEFAULT_DEPTH = 3;

  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid slot at the pipeline input; upstream ready is simply "slot empty" and is therefore a register.
module pipe_skid_buf #(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid_i,
  output logic            up_ready_o,
  input  logic [SIZE-1:0] up_data_i,
  output logic            dn_valid_o,
  input  logic            dn_ready_i,
  output logic [SIZE-1:0] dn_data_o
);

  logic            full_q, full_d;
  logic [SIZE-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (dn_ready_i) full_d = 1'b0;
    end else if (up_valid_i && !dn_ready_i) begin
      full_d = 1'b1;
      data_d = up_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  // While empty, upstream data passes straight through to stage 1.
  assign up_ready_o = !full_q;
  assign dn_valid_o = full_q || up_valid_i;
  assign dn_data_o  = full_q ? data_q : up_data_i;

endmodule

// File: rtl/elastic_pipe_3.sv
// Elastic valid/ready pipeline: DEPTH register stages with bubble collapsing behind a registered-ready skid slot.
module elastic_pipe_3
  import pipe_pkg::*;
#(
  parameter int SIZE  = 1,
  parameter int DEPTH = PIPE_DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SIZE-1:0]             in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SIZE-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OW = occ_width(DEPTH);

  pipe_hs_t                    sk_hs;
  logic [SIZE-1:0]             sk_d;
  logic [DEPTH:1]              stg_v;
  logic [DEPTH:1][SIZE-1:0]    stg_d;
  logic [DEPTH+1:1]            take;
  logic                        in_xfer, out_xfer;
  logic [OW-1:0]               occ_q, occ_d;

  pipe_skid_buf #(.SIZE(SIZE)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .up_valid_i (in_valid),
    .up_ready_o (in_ready),
    .up_data_i  (in_data),
    .dn_valid_o (sk_hs.valid),
    .dn_ready_i (sk_hs.ready),
    .dn_data_o  (sk_d)
  );

  // take[k]: stage k can load this cycle -- it is empty (a bubble) or it hands its beat onward.
  always_comb begin
    take            = '0;
    take[DEPTH+1]   = out_ready;
    for (int k = DEPTH; k >= 1; k--) take[k] = !stg_v[k] || take[k+1];
  end

  assign sk_hs.ready = take[1];

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
    logic            src_v;
    logic [SIZE-1:0] src_d;
    logic            v_q, v_d;
    logic [SIZE-1:0] d_q, d_d;

    if (k == 1) begin : g_head
      assign src_v = sk_hs.valid;
      assign src_d = sk_d;
    end else begin : g_body
      assign src_v = stg_v[k-1];
      assign src_d = stg_d[k-1];
    end

    always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (take[k]) v_d = src_v;
      if (take[k] && src_v) d_d = src_d;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

    assign stg_v[k] = v_q;
    assign stg_d[k] = d_q;
  end

  assign out_valid = stg_v[DEPTH];
  assign out_data  = stg_d[DEPTH];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign occ_d     = occ_q + OW'(in_xfer) - OW'(out_xfer);
  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

`ifndef SYNTHESIS
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable(out_data));
  a_occ_bound: assert property (@(posedge clk) 32'(occupancy) <= DEPTH + 1);
`endif

endmodule

// File: tb/tb_elastic_pipe_3.sv
// Self-checking bench for elastic_pipe_3 (SIZE=8, DEPTH=3) against a queue-based reference model.
module tb_elastic_pipe_3;

  localparam int SIZE  = 8;
  localparam int DEPTH = 3;
  localparam int CAP   = DEPTH + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] out_data;
  logic [2:0]      occupancy;

  int total = 0;
  int bad   = 0;

  elastic_pipe_3 #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    // fill while stalled, then reset mid-traffic
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL prefill_occ got=%0d want=4", occupancy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL midrst_out_data got=%0h want=0", out_data); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL midrst_occ got=%0d want=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c < DEPTH) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early c=%0d got=%0b want=0", c, out_valid); end
      end else if (c == DEPTH) begin
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA5)
          begin bad++; $display("FAIL lat_arrive got=%0b/%0h want=1/a5", out_valid, out_data); end
      end else begin
        total++; if (occupancy !== 3'd0 || out_valid !== 1'b0)
          begin bad++; $display("FAIL lat_drain got=%0d/%0b want=0/0", occupancy, out_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_rate();
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 130 && got < 100; c++) begin
      if (c < 100) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rate_in_ready c=%0d got=%0b want=1", c, in_ready); end
      end
      if (out_valid === 1'b1) begin
        total++; if (out_data !== 8'(got)) begin bad++; $display("FAIL rate_data got=%0d want=%0d", out_data, got); end
        total++; if (c !== got + DEPTH) begin bad++; $display("FAIL rate_timing beat=%0d got_cycle=%0d want=%0d", got, c, got + DEPTH); end
        got++;
      end
      in_valid = (c < 100); in_data = 8'(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (got !== 100) begin bad++; $display("FAIL rate_count got=%0d want=100", got); end
  endtask

  task automatic test_backpressure();
    int  nxt = 1;
    int  exp = 1;
    logic xfer;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c >= CAP) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%0b want=0", c, in_ready); end
        total++; if (out_valid !== 1'b1 || out_data !== 8'd1)
          begin bad++; $display("FAIL bp_hold c=%0d got=%0b/%0d want=1/1", c, out_valid, out_data); end
      end
      in_valid = 1'b1; in_data = 8'(nxt); xfer = in_ready;
      @(negedge clk);
      if (xfer) nxt++;
    end
    total++; if (nxt - 1 !== CAP) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", nxt - 1, CAP); end
    total++; if (occupancy !== 3'(CAP)) begin bad++; $display("FAIL bp_occ got=%0d want=%0d", occupancy, CAP); end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && exp <= 12; c++) begin
      in_valid = (nxt <= 12); in_data = 8'(nxt);
      xfer = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        total++; if (out_data !== 8'(exp)) begin bad++; $display("FAIL bp_release got=%0d want=%0d", out_data, exp); end
        exp++;
      end
      @(negedge clk);
      if (xfer) nxt++;
    end
    in_valid = 1'b0;
    total++; if (exp !== 13) begin bad++; $display("FAIL bp_release_count got=%0d want=13", exp - 1); end
  endtask

  task automatic test_bubble();
    int         ocyc[$];
    logic [7:0] odat[$];
    for (int c = 0; c < 16; c++) begin
      in_valid  = (c == 0 || c == 5);
      in_data   = (c == 0) ? 8'h3C : 8'hC3;
      out_ready = (c >= 10);
      if (c == 10) begin
        total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL bub_occ got=%0d want=2", occupancy); end
      end
      if (out_valid === 1'b1 && out_ready) begin ocyc.push_back(c); odat.push_back(out_data); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (ocyc.size() !== 2) begin bad++; $display("FAIL bub_count got=%0d want=2", ocyc.size()); end
    else begin
      total++; if (ocyc[0] !== 10 || odat[0] !== 8'h3C)
        begin bad++; $display("FAIL bub_beat0 got=c%0d/%0h want=c10/3c", ocyc[0], odat[0]); end
      total++; if (ocyc[1] !== 11 || odat[1] !== 8'hC3)
        begin bad++; $display("FAIL bub_beat1 got=c%0d/%0h want=c11/c3", ocyc[1], odat[1]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int sent = 0;
    int rcvd = 0;
    for (int c = 0; c < 60000 && rcvd < 10000; c++) begin
      total++; if (int'(occupancy) !== q.size())
        begin bad++; $display("FAIL rnd_occ c=%0d got=%0d want=%0d", c, occupancy, q.size()); end
      total++; if (in_ready !== (q.size() < CAP))
        begin bad++; $display("FAIL rnd_in_ready c=%0d got=%0b want=%0b", c, in_ready, q.size() < CAP); end
      if (q.size() == 0) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_empty_valid c=%0d got=%0b want=0", c, out_valid); end
      end
      in_valid  = (sent < 10000) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL rnd_data c=%0d got=%0h want=none", c, out_data); end
        else begin
          if (out_data !== q[0]) begin bad++; $display("FAIL rnd_data c=%0d got=%0h want=%0h", c, out_data, q[0]); end
          void'(q.pop_front());
        end
        rcvd++;
      end
      if (in_valid && in_ready === 1'b1) begin q.push_back(in_data); sent++; end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (rcvd !== 10000) begin bad++; $display("FAIL rnd_count got=%0d want=10000", rcvd); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_rate();
    do_reset();
    test_backpressure();
    do_reset();
    test_bubble();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
